// File: rtl/bitmanip_pkg.sv
// Shared definitions for the bit-manipulation logic unit: opcodes, FSM
// state encoding and count-width helpers.
package bitmanip_pkg;

  localparam logic [3:0] OP_ZERO   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SEXT16 = 4'b0100;
  localparam logic [3:0] OP_SEXT8  = 4'b0101;
  localparam logic [3:0] OP_ZEXT16 = 4'b0110;
  localparam logic [3:0] OP_ZEXT8  = 4'b0111;
  localparam logic [3:0] OP_POPC   = 4'b1000;
  localparam logic [3:0] OP_CLZ    = 4'b1001;
  localparam logic [3:0] OP_CTZ    = 4'b1010;
  localparam logic [3:0] OP_BREV   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold a count in the range 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Opcodes 10xx are the scanned (multi-cycle) class; 11xx are reserved.
  function automatic logic is_multi(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/bitmanip_chunk_scan.sv
// Combinational per-chunk helper: popcount, leading or trailing zero count
// (suppressed once an earlier chunk already held a 1), and bit-reversal.
module bitmanip_chunk_scan #(
  parameter int CHUNK = 4,
  parameter int PW    = bitmanip_pkg::cnt_width(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk_i,
  input  logic             found_i,
  input  logic             msb_first_i,
  output logic [PW-1:0]    pop_o,
  output logic [PW-1:0]    zcnt_o,
  output logic             hit_o,
  output logic [CHUNK-1:0] rev_o
);

  logic [PW-1:0] lead;
  logic [PW-1:0] trail;
  logic          lead_seen;
  logic          trail_seen;

  // Walk the chunk from both ends at once; direction is chosen at the output.
  always_comb begin
    pop_o      = '0;
    rev_o      = '0;
    lead       = '0;
    trail      = '0;
    lead_seen  = 1'b0;
    trail_seen = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      pop_o    = pop_o + PW'(chunk_i[i]);
      rev_o[i] = chunk_i[CHUNK-1-i];
      if (!lead_seen) begin
        if (chunk_i[CHUNK-1-i]) lead_seen = 1'b1;
        else                    lead      = lead + PW'(1);
      end
      if (!trail_seen) begin
        if (chunk_i[i]) trail_seen = 1'b1;
        else            trail      = trail + PW'(1);
      end
    end
    zcnt_o = found_i ? '0 : (msb_first_i ? lead : trail);
  end

  assign hit_o = |chunk_i;

endmodule

// File: rtl/bitmanip_logic_unit.sv
// Variable-latency execute-stage unit: single-cycle logic/extend ops plus
// popcount/clz/ctz/bit-reverse scanned CHUNK bits per cycle.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | multi-cycle op in flight, busy=1, one chunk per cycle
// DONE  | result just written, done=1; may accept the next op
module bitmanip_logic_unit
  import bitmanip_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operantA,
  input  logic [WIDTH-1:0] operantB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CTR_W  = $clog2(NCHUNK + 1);
  localparam int PW     = cnt_width(CHUNK);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             found_q, found_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             msb_first;
  logic [CHUNK-1:0] chunk;
  logic [PW-1:0]    pop;
  logic [PW-1:0]    zcnt;
  logic             hit;
  logic [CHUNK-1:0] rev;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] single_res;
  logic             accept;

  // clz consumes the operand from the top; everything else from the bottom.
  assign msb_first = (op_q == OP_CLZ);
  assign chunk     = msb_first ? opnd_q[WIDTH-1 -: CHUNK] : opnd_q[CHUNK-1:0];
  assign accept    = start && (state_q != ST_SCAN);

  bitmanip_chunk_scan #(.CHUNK(CHUNK), .PW(PW)) u_scan (
    .chunk_i     (chunk),
    .found_i     (found_q),
    .msb_first_i (msb_first),
    .pop_o       (pop),
    .zcnt_o      (zcnt),
    .hit_o       (hit),
    .rev_o       (rev)
  );

  // Accumulator update for one scan cycle; reversed chunks are pushed in at
  // the bottom so the first (lowest) chunk ends up at the top.
  always_comb begin
    acc_step = acc_q;
    case (op_q)
      OP_POPC:         acc_step = acc_q + WIDTH'(pop);
      OP_CLZ, OP_CTZ:  acc_step = acc_q + WIDTH'(zcnt);
      default:         acc_step = (acc_q << CHUNK) | WIDTH'(rev);
    endcase
  end

  // Single-cycle logic/extend results, computed straight from the inputs.
  always_comb begin
    single_res = '0;
    case (opcode)
      OP_AND:    single_res = operantA & operantB;
      OP_OR:     single_res = operantA | operantB;
      OP_XOR:    single_res = operantA ^ operantB;
      OP_SEXT16: single_res = WIDTH'($signed(operantA[15:0]));
      OP_SEXT8:  single_res = WIDTH'($signed(operantA[7:0]));
      OP_ZEXT16: single_res = WIDTH'(operantA[15:0]);
      OP_ZEXT8:  single_res = WIDTH'(operantA[7:0]);
      default:   single_res = '0;
    endcase
  end

  // Next-state logic; flush wins over everything and leaves the result alone.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    found_d  = found_q;
    op_d     = op_q;
    result_d = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_SCAN: begin
          opnd_d  = msb_first ? (opnd_q << CHUNK) : (opnd_q >> CHUNK);
          acc_d   = acc_step;
          found_d = found_q | hit;
          cnt_d   = cnt_q + CTR_W'(1);
          if (cnt_q == CTR_W'(NCHUNK - 1)) begin
            state_d  = ST_DONE;
            result_d = acc_step;
            cnt_d    = '0;
          end
        end
        default: begin
          if (accept) begin
            if (is_multi(opcode)) begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              opnd_d  = operantA;
              acc_d   = '0;
              found_d = 1'b0;
              op_d    = opcode;
            end else begin
              state_d  = ST_DONE;
              result_d = single_res;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      found_q  <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      found_q  <= found_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_SCAN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_bitmanip_logic_unit.sv
// Self-checking bench for bitmanip_logic_unit (WIDTH=32, CHUNK=4): a
// latency-level behavioural model checked every cycle, directed literal
// cases and a randomized stream.
module tb_bitmanip_logic_unit;

  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int NCH = W / CH;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [3:0]   opcode;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  bitmanip_logic_unit #(.WIDTH(W), .CHUNK(CH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .opcode   (opcode),
    .operantA (opA),
    .operantB (opB),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of any opcode, straight from the operation definitions.
  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    r = '0;
    case (op)
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = {{16{a[15]}}, a[15:0]};
      4'd5: r = {{24{a[7]}}, a[7:0]};
      4'd6: r = {16'h0, a[15:0]};
      4'd7: r = {24'h0, a[7:0]};
      4'd8: begin
        n = 0;
        for (int i = 0; i < W; i++) if (a[i]) n++;
        r = W'(n);
      end
      4'd9: begin
        n = W;
        for (int i = 0; i < W; i++) if (a[i]) n = W - 1 - i;
        r = W'(n);
      end
      4'd10: begin
        n = W;
        for (int i = W - 1; i >= 0; i--) if (a[i]) n = i;
        r = W'(n);
      end
      4'd11: for (int i = 0; i < W; i++) r[i] = a[W-1-i];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Latency-level model: cycles of scanning left, done pulse, held result.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_result;
  logic [W-1:0] m_pend;

  // Model advances once per rising edge using the inputs driven before it.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_result = '0;
      m_pend   = '0;
    end else begin
      m_done = 1'b0;
      if (flush) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end else if (start) begin
        if (opcode[3:2] == 2'b10) begin
          m_left = NCH;
          m_pend = ref_op(opcode, opA, opB);
        end else begin
          m_done   = 1'b1;
          m_result = ref_op(opcode, opA, opB);
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    #1;
    if (cmp_en) begin
      check("cyc_busy", W'(busy), W'(m_left > 0));
      check("cyc_done", W'(done), W'(m_done));
      check("cyc_result", result, m_result);
    end
  end

  task automatic run_multi(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] exp,
                           input string name, input bit noise);
    int lat;
    int busy_cyc;
    lat      = 0;
    busy_cyc = 0;
    start    = 1'b1;
    opcode   = op;
    opA      = a;
    opB      = $urandom;
    do begin
      @(negedge clock);
      lat++;
      if (busy) busy_cyc++;
      if (busy && noise) begin
        start  = 1'($urandom_range(0, 1));
        opcode = 4'($urandom);
        opA    = $urandom;
        opB    = $urandom;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 30);
    start = 1'b0;
    check({name, "_latency"}, W'(lat), W'(NCH + 1));
    check({name, "_busy_cycles"}, W'(busy_cyc), W'(NCH));
    check({name, "_result"}, result, exp);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    opcode = '0;
    opA    = '0;
    opB    = '0;

    // Hand-computed pins of the model itself.
    check("pin_popc", ref_op(4'd8, 32'hFFFF_0001, '0), 32'd17);
    check("pin_clz", ref_op(4'd9, 32'h0001_0000, '0), 32'd15);
    check("pin_ctz", ref_op(4'd10, 32'h0001_0000, '0), 32'd16);
    check("pin_brev", ref_op(4'd11, 32'h1234_5678, '0), 32'h1E6A_2C48);

    repeat (3) @(negedge clock);
    reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clock);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);

    // Back-to-back single-cycle ops.
    start = 1'b1; opcode = 4'b0001; opA = 32'hF0F0_1234; opB = 32'h0FF0_FFFF;
    @(negedge clock);
    check("and_done", W'(done), 32'd1);
    check("and_result", result, 32'h00F0_1234);
    opcode = 4'b0101; opA = 32'h0000_0080; opB = 32'h0;
    @(negedge clock);
    check("sext8_done", W'(done), 32'd1);
    check("sext8_result", result, 32'hFFFF_FF80);
    start = 1'b0;
    @(negedge clock);

    run_multi(4'b1000, 32'hFFFF_0001, 32'd17, "popc", 1'b1);
    run_multi(4'b1001, 32'h0001_0000, 32'd15, "clz", 1'b0);
    run_multi(4'b1010, 32'h0001_0000, 32'd16, "ctz", 1'b1);
    run_multi(4'b1001, 32'h0000_0000, 32'd32, "clz0", 1'b0);
    run_multi(4'b1010, 32'h0000_0000, 32'd32, "ctz0", 1'b0);
    run_multi(4'b1011, 32'h0000_0001, 32'h8000_0000, "brev1", 1'b1);
    run_multi(4'b1011, 32'h1234_5678, 32'h1E6A_2C48, "brev2", 1'b0);

    // Flush at scan cycle 4 together with a start.
    start = 1'b1; opcode = 4'b1000; opA = 32'hFFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    flush = 1'b1; start = 1'b1; opcode = 4'b0010; opA = 32'h1111_1111; opB = 32'h2222_2222;
    @(negedge clock);
    check("flush_busy", W'(busy), '0);
    check("flush_done", W'(done), '0);
    check("flush_result", result, 32'h1E6A_2C48);
    flush = 1'b0;
    start = 1'b1; opcode = 4'b0011; opA = 32'hFFFF_0000; opB = 32'h0F0F_0F0F;
    @(negedge clock);
    check("post_flush_done", W'(done), 32'd1);
    check("post_flush_result", result, 32'hF0F0_0F0F);
    start = 1'b0;
    @(negedge clock);

    // Reset in the middle of a scan.
    start = 1'b1; opcode = 4'b1001; opA = 32'h0000_00FF;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_result", result, '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (NCH + 2) @(negedge clock);
    check("midrst_no_done", W'(done), '0);

    // Randomized stream with flushes and starts while busy.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      start  = ($urandom_range(0, 2) != 0);
      opcode = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       opA = '0;
        1:       opA = '1;
        2:       opA = W'(1) << $urandom_range(0, W - 1);
        default: opA = $urandom;
      endcase
      opB   = $urandom;
      flush = ($urandom_range(0, 24) == 0);
    end
    @(negedge clock);
    start = 1'b0;
    flush = 1'b0;
    repeat (NCH + 3) @(negedge clock);
    cmp_en = 1'b0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
